serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial ripple adder; the addition counterpart of the team's 1-bit borrow-chain Subtractor.
- Processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Replaces a WIDTH-deep combinational carry chain with WIDTH clock cycles of latency.
- Sits in the datapath beside the subtractor cells; controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).
- CW, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- carry_in  input  1  initial carry; captured on accepted start.
- busy  output  1  high while the operation is in progress (state RUN).
- done  output  1  one-cycle pulse; sum and carry_out valid.
- sum  output  WIDTH  registered result, (a+b+carry_in) mod 2^WIDTH.
- carry_out  output  1  registered final carry, bit WIDTH of a+b+carry_in.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, sum=0, carry_out=0. Internal shift registers, carry FF and counter are cleared.
- Reset has priority over all other inputs in every state. A reset mid-RUN aborts the operation, produces no done pulse, and leaves sum=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch a_sh=a, b_sh=b, c=carry_in, cnt=0.
  - Go to RUN.
  - busy=1 from E0 onward.
- IDLE, start=0: hold state; sum and carry_out hold their last values.
- RUN, each edge:
  - s_bit = a_sh[0]^b_sh[0]^c.
  - c <= a_sh[0]&b_sh[0] | c&(a_sh[0]^b_sh[0]).
  - a_sh and b_sh shift right one bit.
  - acc shifts right with s_bit inserted at MSB.
  - cnt increments.
- RUN, edge where cnt==WIDTH-1 (edge E_WIDTH):
  - Last bit is processed.
  - sum <= final acc value (including this bit); carry_out <= final carry.
  - Go to DONE; busy=0, done=1.
- DONE: exactly one cycle. The next edge goes to IDLE with done=0.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clock cycles after busy rises.
- start is ignored in RUN and DONE; no queuing.
  - The earliest next accept is the IDLE cycle after DONE.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Operand changes on a, b, or carry_in after acceptance have no effect on the result in progress.
- sum and carry_out change only on entering DONE (or on reset), and are stable otherwise.
- No overflow flag: carry_out is the unsigned overflow. Signed interpretation is the consumer's responsibility.

Test Plan:
- WIDTH=8, a=0x3C, b=0x15, carry_in=0, start 1 cycle -> busy high for 8 cycles; done pulses once; sum=0x51, carry_out=0.
- a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1. Checks full carry ripple across all bits.
- a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1. Also a=0x00, b=0x00, carry_in=0 -> sum=0x00, carry_out=0.
- Start accepted, then a/b changed and start re-asserted during RUN -> original result delivered, a single done pulse; the second start is ignored.
- rst asserted at the 4th RUN cycle of a=0xAA, b=0x55 -> next cycle busy=0, done=0, sum=0, carry_out=0; no done pulse for the aborted operation.
- start held continuously high with randomized operands over 1000 operations -> each result matches the a+b+carry_in reference model, and each accept spaces exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// Start/busy/done handshake; result lands in sum/carry_out on entering DONE.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_sbit;
    logic             w_cnext;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_sbit  = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_cnext = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    // The oldest sum bit never needs to be held: it drops off the bottom
    // on the final shift straight into the sum register.
    assign w_acc_next = {w_sbit, r_acc};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:              w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_c    <= carry_in;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_acc  <= w_acc_next[WIDTH-1:1];
                    r_c    <= w_cnext;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_cnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule
